clkdiv_period_meter: RTL
========================

Name: clkdiv_period_meter

Overview:
- Receive-side companion to the programmable clock divider: samples a divided clock (toggling every UPTO+1 clk cycles) and recovers the divider's UPTO setting.
- Measures the interval between successive edges, reports the recovered value with a strobe, and declares lock after repeated matching measurements.
- Used as a self-check and loopback monitor beside divider instances on the same system clock.

Parameters:
- CNT_W, 32, width of interval counter and recovered value.
- LOCK_COUNT, 4, consecutive matching measurements required to assert locked (legal range 2..15).
- TIMEOUT_CYCLES, 100000000, cycles without an edge before declaring stall (must be < 2^CNT_W - 1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- div_in  in  1  divided clock under measurement; may be asynchronous.
- upto_out  out  CNT_W  recovered divider setting (edge interval minus 1).
- meas_valid  out  1  one-cycle strobe; upto_out updated the same cycle.
- locked  out  1  LOCK_COUNT consecutive equal measurements seen.
- stalled  out  1  no edge for TIMEOUT_CYCLES.

Behaviour:
- Reset (rst_n=0 at posedge): upto_out=0, meas_valid=0, locked=0, stalled=0, synchroniser FFs=0, counter=0, match count=0, state=WAIT_FIRST.
- Input path:
  - 2-FF synchroniser, then one delay register.
  - Edge detect is the XOR of synchronised and delayed values; both rising and falling edges count.
  - Edge pulse occurs 3 clk after a div_in transition. Latency is constant, so intervals are unaffected.
- Interval counter:
  - Cleared to 0 in the edge-pulse cycle, otherwise increments; it saturates at all-ones and does not wrap.
  - Interval E = counter value at the edge pulse + 1, i.e. clk cycles between consecutive edge pulses.
- FSM states:
  - WAIT_FIRST: the first edge only starts the counter; no output. Go to MEASURE.
  - MEASURE: each edge registers upto_out = E-1 and pulses meas_valid the next cycle (4 clk after the div_in transition).
    - If E-1 equals the previous upto_out, increment match count; otherwise set it to 1.
    - When match count reaches LOCK_COUNT, set locked=1 and go to LOCKED.
  - LOCKED: keep measuring and pulsing meas_valid. A mismatched measurement clears locked, sets match count=1 and returns to MEASURE; upto_out takes the new value.
- Timeout:
  - Counter reaching TIMEOUT_CYCLES in any state except WAIT_FIRST sets stalled=1, clears locked and match count, and goes to WAIT_FIRST.
  - upto_out holds its last value.
  - stalled clears on the next edge pulse.
- Edge pulse and timeout in the same cycle: the edge wins; no stall.
- Minimum interval: div_in toggling every clk (UPTO=0) gives E=1, upto_out=0; this is legal.
- Faster-than-clk toggling is aliased; behaviour is unspecified.
- Reset mid-measurement discards the partial interval and match history.

Optional Feature:
- Macro: CLKDIV_PERIOD_METER_JITTER_TOL_EN.
- Defined: for the lock/match comparison, a measurement matches if |new - previous upto_out| <= 1. Covers a one-cycle synchroniser sampling-phase shift on asynchronous div_in. upto_out still reports the raw new value.
- Undefined: exact equality required.

Decomposition:
- Shared package:
  - FSM state enum (WAIT_FIRST, MEASURE, LOCKED).
  - Default CNT_W and TIMEOUT_CYCLES constants, also used by the divider bench.
- One sub-module, sync_edge_detect: the 2-FF synchroniser, delay register and any-edge pulse output.
- Counter, compare and FSM stay in the top.

Test Plan:
- Reset, then div_in driven by a divider with UPTO=4 (toggle every 5 clk) -> first meas_valid carries upto_out=4; locked rises on the 4th consecutive strobe; meas_valid then pulses every 5 clk.
- UPTO=0 (div_in toggles every clk, synchronous) -> upto_out=0 on each strobe; locked after 4 strobes.
- Locked at UPTO=9, switch divider to UPTO=6 -> first strobe at the new rate shows upto_out=6 and locked=0; locked reasserts 3 strobes later.
- TIMEOUT_CYCLES=50, div_in frozen after lock -> stalled=1 and locked=0 after 50 cycles without an edge, upto_out held. Resume toggling: stalled clears on the first edge; first meas_valid appears on the second edge.
- Alternate intervals 8,9,8,9 clk on an asynchronous-phase div_in -> without the macro, locked stays 0; with CLKDIV_PERIOD_METER_JITTER_TOL_EN, locked=1 after 4 strobes.
- Assert rst_n=0 for 1 clk mid-interval while locked -> all outputs 0 next cycle; the first strobe after reset requires two fresh edges.

Source files
------------

// File: rtl/clkdiv_period_meter_pkg.sv
// Shared constants and FSM encoding for the divided-clock period meter.
// Optional build macro used by the top: CLKDIV_PERIOD_METER_JITTER_TOL_EN.
package clkdiv_period_meter_pkg;

    localparam int          DEF_CNT_W          = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 100000000;
    localparam int          DEF_LOCK_COUNT     = 4;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        MEASURE    = 2'd1,
        LOCKED     = 2'd2
    } meter_state_e;

endpackage

// File: rtl/clkdiv_period_meter_if.sv
// Bundles the measured clock input and the meter's result outputs.
// Optional build macro affecting the meter: CLKDIV_PERIOD_METER_JITTER_TOL_EN.
interface clkdiv_period_meter_if
    import clkdiv_period_meter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);

    logic             div_in;
    logic [CNT_W-1:0] upto_out;
    logic             meas_valid;
    logic             locked;
    logic             stalled;

    modport master (
        output div_in,
        input  upto_out,
        input  meas_valid,
        input  locked,
        input  stalled
    );

    modport slave (
        input  div_in,
        output upto_out,
        output meas_valid,
        output locked,
        output stalled
    );

endinterface

// File: rtl/clkdiv_period_meter_sync_edge_detect.sv
// Two-flop synchroniser plus delay register; pulses for one clk on either edge of din.
// Optional build macro affecting the parent: CLKDIV_PERIOD_METER_JITTER_TOL_EN.
module clkdiv_period_meter_sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic edge_pulse
);

    logic meta;
    logic sync;
    logic dly;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            dly  <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            dly  <= sync;
        end
    end

    assign edge_pulse = sync ^ dly;

endmodule

// File: rtl/clkdiv_period_meter.sv
// Recovers a clock divider's UPTO setting from the interval between divided-clock edges.
// Build macro CLKDIV_PERIOD_METER_JITTER_TOL_EN relaxes the lock comparison to +/-1.
module clkdiv_period_meter
    import clkdiv_period_meter_pkg::*;
#(
    parameter int          CNT_W          = DEF_CNT_W,
    parameter int          LOCK_COUNT     = DEF_LOCK_COUNT,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    clkdiv_period_meter_if.slave bus
);

    localparam logic [1:0] ST_WAIT_FIRST = WAIT_FIRST;
    localparam logic [1:0] ST_MEASURE    = MEASURE;
    localparam logic [1:0] ST_LOCKED     = LOCKED;

    localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic             edge_pulse;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] upto_q;
    logic             valid_q;
    logic             locked_q;
    logic             stalled_q;
    logic [3:0]       match_cnt;
    logic [3:0]       match_inc;
    logic [1:0]       state;
    logic             is_match;
    logic             timeout_hit;

    clkdiv_period_meter_sync_edge_detect u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (bus.div_in),
        .edge_pulse (edge_pulse)
    );

`ifdef CLKDIV_PERIOD_METER_JITTER_TOL_EN
    logic [CNT_W-1:0] diff;

    always_comb begin
        diff     = (cnt >= upto_q) ? (cnt - upto_q) : (upto_q - cnt);
        is_match = (diff <= CNT_W'(1));
    end
`else
    always_comb begin
        is_match = (cnt == upto_q);
    end
`endif

    // The counter value at the edge pulse is already E-1, i.e. the new UPTO.
    always_comb begin
        match_inc   = (match_cnt >= LOCK_TARGET) ? LOCK_TARGET : match_cnt + 4'd1;
        timeout_hit = (state != ST_WAIT_FIRST) && (cnt == TIMEOUT_VAL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            upto_q    <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            stalled_q <= 1'b0;
            match_cnt <= '0;
            state     <= ST_WAIT_FIRST;
        end else begin
            valid_q <= 1'b0;

            if (edge_pulse) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end

            // An edge always takes priority over a coincident timeout.
            if (edge_pulse) begin
                stalled_q <= 1'b0;
                if (state == ST_WAIT_FIRST) begin
                    state <= ST_MEASURE;
                end else begin
                    upto_q  <= cnt;
                    valid_q <= 1'b1;
                    if (is_match) begin
                        match_cnt <= match_inc;
                        if (match_inc == LOCK_TARGET) begin
                            locked_q <= 1'b1;
                            state    <= ST_LOCKED;
                        end
                    end else begin
                        match_cnt <= 4'd1;
                        locked_q  <= 1'b0;
                        state     <= ST_MEASURE;
                    end
                end
            end else if (timeout_hit) begin
                stalled_q <= 1'b1;
                locked_q  <= 1'b0;
                match_cnt <= '0;
                state     <= ST_WAIT_FIRST;
            end
        end
    end

    assign bus.upto_out   = upto_q;
    assign bus.meas_valid = valid_q;
    assign bus.locked     = locked_q;
    assign bus.stalled    = stalled_q;

endmodule
